// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the core-to-RAM request arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        FETCH,
        DONE
    } arb_state_t;

    typedef enum logic [1:0] {
        ACC_LOAD,
        ACC_STORE,
        ACC_FETCH
    } acc_kind_t;

    localparam logic [1:0]  ALIGN_MASK = 2'h3;
    localparam logic [63:0] ERR_WORD   = '0;

    // Word accesses only: any set low address bit is a bus error.
    function automatic logic addr_misaligned(input logic [1:0] lsb);
        return |(lsb & ALIGN_MASK);
    endfunction

endpackage

// File: rtl/mem_request_arbiter_if.sv
// Core request/response and RAM port signals of the memory request arbiter.
interface mem_request_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);

    logic              i_ren;
    logic [ADDR_W-1:0] imemaddr;
    logic [DATA_W-1:0] imemload;
    logic              i_ready;
    logic              d_ren;
    logic              d_wen;
    logic [ADDR_W-1:0] dmmaddr;
    logic [DATA_W-1:0] dmmstore;
    logic [DATA_W-1:0] dmmload;
    logic              d_ready;
    logic              bus_err;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_store;
    logic              ram_ren;
    logic              ram_wen;
    logic [DATA_W-1:0] ram_load;
    logic              ram_ready;

    // Arbiter side: serves the core requests and drives the RAM port.
    modport slave (
        input  i_ren, imemaddr, d_ren, d_wen, dmmaddr, dmmstore, ram_load, ram_ready,
        output imemload, i_ready, dmmload, d_ready, bus_err,
               ram_addr, ram_store, ram_ren, ram_wen
    );

    // Environment side: core requesters plus the RAM responder.
    modport master (
        output i_ren, imemaddr, d_ren, d_wen, dmmaddr, dmmstore, ram_load, ram_ready,
        input  imemload, i_ready, dmmload, d_ready, bus_err,
               ram_addr, ram_store, ram_ren, ram_wen
    );

endinterface

// File: rtl/wait_timer.sv
// Saturating RAM wait-state counter; expired flags the wait that reaches TIMEOUT.
module wait_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic nRST,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tick && (count_q != CNT_W'(TIMEOUT))) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Combinational so the FSM can abort in the same cycle the limit is hit.
    assign expired = tick && (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_request_arbiter.sv
// Arbitrates core fetch and load/store requests onto a single RAM port,
// with alignment checking and a wait-state timeout.
module mem_request_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  nRST,
    mem_request_arbiter_if.slave  bus
);

    arb_state_t        state_q, state_d;
    acc_kind_t         acc_q, acc_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_store_q, ram_store_d;
    logic              ram_ren_q, ram_ren_d;
    logic              ram_wen_q, ram_wen_d;
    logic [DATA_W-1:0] imemload_q, imemload_d;
    logic [DATA_W-1:0] dmmload_q, dmmload_d;
    logic              i_ready_q, i_ready_d;
    logic              d_ready_q, d_ready_d;
    logic              bus_err_q, bus_err_d;
    logic              tmr_clear_c, tmr_tick_c, tmr_expired;

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .nRST    (nRST),
        .clear   (tmr_clear_c),
        .tick    (tmr_tick_c),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            acc_q       <= ACC_LOAD;
            ram_addr_q  <= '0;
            ram_store_q <= '0;
            ram_ren_q   <= 1'b0;
            ram_wen_q   <= 1'b0;
            imemload_q  <= '0;
            dmmload_q   <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ram_addr_q  <= ram_addr_d;
            ram_store_q <= ram_store_d;
            ram_ren_q   <= ram_ren_d;
            ram_wen_q   <= ram_wen_d;
            imemload_q  <= imemload_d;
            dmmload_q   <= dmmload_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
            bus_err_q   <= bus_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ram_addr_d  = ram_addr_q;
        ram_store_d = ram_store_q;
        ram_ren_d   = ram_ren_q;
        ram_wen_d   = ram_wen_q;
        imemload_d  = imemload_q;
        dmmload_d   = dmmload_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        bus_err_d   = 1'b0;
        tmr_clear_c = 1'b0;
        tmr_tick_c  = 1'b0;

        unique case (state_q)
            IDLE: begin
                tmr_clear_c = 1'b1;
                // Data first: the current instruction's load/store precedes the next fetch.
                if (bus.d_ren || bus.d_wen) begin
                    if (addr_misaligned(bus.dmmaddr[1:0])) begin
                        state_d   = DONE;
                        d_ready_d = 1'b1;
                        bus_err_d = 1'b1;
                        dmmload_d = DATA_W'(ERR_WORD);
                    end else begin
                        state_d     = DATA;
                        acc_d       = bus.d_wen ? ACC_STORE : ACC_LOAD;
                        ram_addr_d  = bus.dmmaddr;
                        ram_store_d = bus.dmmstore;
                        ram_wen_d   = bus.d_wen;
                        ram_ren_d   = ~bus.d_wen;
                    end
                end else if (bus.i_ren) begin
                    if (addr_misaligned(bus.imemaddr[1:0])) begin
                        state_d    = DONE;
                        i_ready_d  = 1'b1;
                        bus_err_d  = 1'b1;
                        imemload_d = DATA_W'(ERR_WORD);
                    end else begin
                        state_d     = FETCH;
                        acc_d       = ACC_FETCH;
                        ram_addr_d  = bus.imemaddr;
                        ram_store_d = '0;
                        ram_wen_d   = 1'b0;
                        ram_ren_d   = 1'b1;
                    end
                end
            end

            DATA, FETCH: begin
                tmr_tick_c = ~bus.ram_ready;
                if (bus.ram_ready) begin
                    state_d   = DONE;
                    ram_ren_d = 1'b0;
                    ram_wen_d = 1'b0;
                    if (acc_q == ACC_FETCH) begin
                        imemload_d = bus.ram_load;
                        i_ready_d  = 1'b1;
                    end else begin
                        d_ready_d = 1'b1;
                        if (acc_q == ACC_LOAD) begin
                            dmmload_d = bus.ram_load;
                        end
                    end
                end else if (tmr_expired) begin
                    // Abort: a store leaves dmmload untouched, reads return the error word.
                    state_d   = DONE;
                    ram_ren_d = 1'b0;
                    ram_wen_d = 1'b0;
                    bus_err_d = 1'b1;
                    if (acc_q == ACC_FETCH) begin
                        imemload_d = DATA_W'(ERR_WORD);
                        i_ready_d  = 1'b1;
                    end else begin
                        d_ready_d = 1'b1;
                        if (acc_q == ACC_LOAD) begin
                            dmmload_d = DATA_W'(ERR_WORD);
                        end
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_store = ram_store_q;
    assign bus.ram_ren   = ram_ren_q;
    assign bus.ram_wen   = ram_wen_q;
    assign bus.imemload  = imemload_q;
    assign bus.dmmload   = dmmload_q;
    assign bus.i_ready   = i_ready_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Bench for mem_request_arbiter: RAM model with programmable wait states,
// request vector table and a response scoreboard.
module tb_mem_request_arbiter;

    localparam int unsigned TO = 4;

    typedef struct {
        logic        i_ren;
        logic        d_ren;
        logic        d_wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic        exp_err;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic        is_fetch;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic clk  = 1'b0;
    logic nRST = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t vecs[16];

    always #5 clk = ~clk;

    mem_request_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_request_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .clk  (clk),
        .nRST (nRST),
        .bus  (bus)
    );

    // RAM model: ready after ram_wait stalled cycles of a held strobe.
    logic [31:0] mem [0:255];
    int          ram_wait = 0;
    int          wcnt;

    assign bus.ram_ready = (bus.ram_ren || bus.ram_wen) && (wcnt == ram_wait);
    assign bus.ram_load  = bus.ram_ren ? mem[bus.ram_addr[9:2]] : 32'h0;

    always @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            wcnt <= 0;
            for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + 32'(i);
            mem[0]  <= 32'h1234_5678;
            mem[32] <= 32'h0bad_beef;
            mem[64] <= 32'h0050_0093;
        end else begin
            if ((bus.ram_ren || bus.ram_wen) && !bus.ram_ready) wcnt <= wcnt + 1;
            else wcnt <= 0;
            if (bus.ram_wen && bus.ram_ready) mem[bus.ram_addr[9:2]] <= bus.ram_store;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s unexpected ready pulse actual=1 required=0", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, " ready"}, 32'({bus.i_ready, bus.d_ready}), e.is_fetch ? 32'h2 : 32'h1);
        chk({tag, " bus_err"}, 32'(bus.bus_err), 32'(e.err));
        chk({tag, " data"}, e.is_fetch ? bus.imemload : bus.dmmload, e.data);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_requests();
        bus.i_ren = 1'b0;
        bus.d_ren = 1'b0;
        bus.d_wen = 1'b0;
    endtask

    initial begin
        logic        misal, got;
        logic [1:0]  exp_strobe;
        int          d_cyc, i_cyc;
        exp_t        e;
        string       tag;

        //        i_ren d_ren d_wen addr          wdata         waits err   exp_data      lat
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0,         0,  1'b0, 32'h0050_0093, 2};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0080, 32'h0,         1,  1'b0, 32'h0bad_beef, 3};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 2,  1'b0, 32'h0bad_beef, 4};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0,         3,  1'b0, 32'hCAFE_F00D, 5};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0042, 32'h0,         0,  1'b1, 32'h0,         1};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h0000_0041, 32'h1234,      0,  1'b1, 32'h0,         1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0102, 32'h0,         0,  1'b1, 32'h0,         1};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0104, 32'h0,         1,  1'b0, 32'h1000_0041, 3};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0080, 32'h55AA_55AA, 0,  1'b0, 32'h0,         2};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0080, 32'h0,         0,  1'b0, 32'h55AA_55AA, 2};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0,         3,  1'b0, 32'h0050_0093, 5};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0,         4,  1'b1, 32'h0,         5};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h0000_0080, 32'h0,         99, 1'b1, 32'h0,         5};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 32'h0000_0040, 32'h0000_0001, 99, 1'b1, 32'h0,         5};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0,         0,  1'b0, 32'hCAFE_F00D, 2};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 32'h0000_0108, 32'h0,         0,  1'b0, 32'h1000_0042, 2};

        drop_requests();
        bus.imemaddr = '0;
        bus.dmmaddr  = '0;
        bus.dmmstore = '0;

        // Reset values.
        cycle();
        cycle();
        nRST = 1'b1;
        chk("rst strobes", 32'({bus.ram_ren, bus.ram_wen}), 32'h0);
        chk("rst ram_addr", bus.ram_addr, 32'h0);
        chk("rst ready/err", 32'({bus.i_ready, bus.d_ready, bus.bus_err}), 32'h0);
        chk("rst imemload", bus.imemload, 32'h0);
        chk("rst dmmload", bus.dmmload, 32'h0);

        // Reset in the middle of a stalled load.
        ram_wait     = 99;
        bus.d_ren    = 1'b1;
        bus.dmmaddr  = 32'h80;
        cycle();
        chk("midrst strobe before", 32'(bus.ram_ren), 32'h1);
        cycle();
        #1;
        nRST = 1'b0;
        #1;
        chk("midrst strobes async", 32'({bus.ram_ren, bus.ram_wen}), 32'h0);
        chk("midrst ram_addr", bus.ram_addr, 32'h0);
        drop_requests();
        #1;
        nRST = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle();
            chk($sformatf("midrst idle c%0d", c),
                32'({bus.i_ready, bus.d_ready, bus.bus_err, bus.ram_ren, bus.ram_wen}), 32'h0);
        end

        // Table-driven single requests.
        foreach (vecs[k]) begin
            tag       = $sformatf("v%0d", k);
            ram_wait  = vecs[k].waits;
            bus.i_ren = vecs[k].i_ren;
            bus.d_ren = vecs[k].d_ren;
            bus.d_wen = vecs[k].d_wen;
            if (vecs[k].i_ren) bus.imemaddr = vecs[k].addr;
            else begin
                bus.dmmaddr  = vecs[k].addr;
                bus.dmmstore = vecs[k].wdata;
            end
            e.is_fetch = vecs[k].i_ren;
            e.err      = vecs[k].exp_err;
            e.data     = vecs[k].exp_data;
            sb.push_back(e);
            misal      = vecs[k].addr[1:0] != 2'b00;
            exp_strobe = vecs[k].d_wen ? 2'b01 : 2'b10;
            got        = 1'b0;
            for (int c = 1; c <= 20; c++) begin
                cycle();
                if (bus.i_ready || bus.d_ready) begin
                    got = 1'b1;
                    chk({tag, " latency"}, 32'(c), 32'(vecs[k].exp_lat));
                    chk({tag, " done strobes"}, 32'({bus.ram_ren, bus.ram_wen}), 32'h0);
                    pop_check(tag);
                    break;
                end else if (misal) begin
                    chk({tag, " no strobe"}, 32'({bus.ram_ren, bus.ram_wen}), 32'h0);
                end else begin
                    chk({tag, " strobe"}, 32'({bus.ram_ren, bus.ram_wen}), 32'(exp_strobe));
                    chk({tag, " ram_addr"}, bus.ram_addr, vecs[k].addr);
                    if (vecs[k].d_wen) chk({tag, " ram_store"}, bus.ram_store, vecs[k].wdata);
                end
            end
            if (!got) begin
                checks++;
                errors++;
                $display("FAIL %s no ready within 20 cycles actual=0 required=1", tag);
                if (sb.size() > 0) void'(sb.pop_front());
            end
            drop_requests();
            cycle();
            chk({tag, " single pulse"}, 32'({bus.i_ready, bus.d_ready}), 32'h0);
        end

        // Simultaneous fetch and load: data served first; requesters drop mid-access.
        ram_wait     = 2;
        bus.i_ren    = 1'b1;
        bus.imemaddr = 32'h100;
        bus.d_ren    = 1'b1;
        bus.dmmaddr  = 32'h2000;
        e.is_fetch = 1'b0; e.err = 1'b0; e.data = 32'h1234_5678;
        sb.push_back(e);
        e.is_fetch = 1'b1; e.err = 1'b0; e.data = 32'h0050_0093;
        sb.push_back(e);
        d_cyc = -1;
        i_cyc = -1;
        for (int c = 1; c <= 15; c++) begin
            cycle();
            if (c == 2) bus.d_ren = 1'b0;
            if (c == 7) bus.i_ren = 1'b0;
            if (bus.i_ready || bus.d_ready) begin
                if (bus.d_ready) d_cyc = c;
                if (bus.i_ready) i_cyc = c;
                pop_check($sformatf("prio c%0d", c));
            end
        end
        chk("prio d_ready cycle", 32'(d_cyc), 32'd4);
        chk("prio i_ready cycle", 32'(i_cyc), 32'd9);
        chk("scoreboard drained", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
